sat_add_arbiter: RTL and testbench
==================================

Name: sat_add_arbiter

Overview:
- Shares one signed saturating adder (two's-complement add, overflow detect, clamp to max positive or max negative) among NUM_REQ requesters.
- Round-robin arbiter with a valid/ready handshake on each request port and on the single response port.
- Registered response carries requester ID, saturated result and overflow flag.
- Saturating overflow-event counter for status/debug; sits between DSP front-end requesters and the shared arithmetic resource.

Parameters:
- DATA_WIDTH, 16: signed operand/result width.
- NUM_REQ, 4: number of requesters, 2..16.
- ID_WIDTH, 2: width of rsp_id; must be ≥ clog2(NUM_REQ).
- CNT_WIDTH, 8: overflow event counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  packed operand A; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_id  out  ID_WIDTH  index of requester that produced the response.
- rsp_result  out  DATA_WIDTH  saturated signed sum.
- rsp_overflow  out  1  high if the sum saturated.
- ovf_count  out  CNT_WIDTH  count of accepted responses with overflow, saturating.
- ovf_clear  in  1  synchronous clear of ovf_count.

Behaviour:

Reset (rst_n low, asynchronous):
- rsp_valid=0, rsp_result=0, rsp_id=0, rsp_overflow=0, ovf_count=0, rr_ptr=0, state=IDLE.
- req_ready=0 while in reset.
- Reset mid-operation discards any pending response; no partial handshake survives.

States:
- IDLE: no response held.
- HOLD: response registered, rsp_valid=1.

Accept condition:
- accept_en = (state==IDLE) | (rsp_valid & rsp_ready).
- Gives one transaction per cycle when rsp_ready stays high.

Arbitration:
- When accept_en is true, grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping mod NUM_REQ.
- req_ready[i] is combinational and asserted only for the granted index; all others are 0.
- req_ready is all-zero when accept_en=0 or no request is valid.
- On a grant, rr_ptr <= (granted+1) mod NUM_REQ; rr_ptr is unchanged otherwise.
- A requester must hold req_valid and its operands stable until it sees req_ready (checked by the bench, not by the RTL).

Datapath (registered on the grant edge, latency 1 cycle, grant to rsp_valid):
- sum = a + b, truncated to DATA_WIDTH.
- ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
- result = ovf ? (a[MSB] ? -2^(DATA_WIDTH-1) : 2^(DATA_WIDTH-1)-1) : sum.
- rsp_result, rsp_overflow and rsp_id load together.

Transitions:
- IDLE -> HOLD on a grant.
- HOLD & rsp_ready & grant -> HOLD, new data loaded.
- HOLD & rsp_ready & no grant -> IDLE; rsp_valid=0, data registers keep their last values.
- HOLD & !rsp_ready -> HOLD; all rsp_* outputs stable, req_ready all 0.

Overflow counter:
- Increments on a response handshake (rsp_valid & rsp_ready) with rsp_overflow=1.
- Saturates at 2^CNT_WIDTH-1; no wrap.
- ovf_clear sets it to 0 on the next edge.
- Clear has priority over a simultaneous increment: result is 0.

Test Plan:
1. Single requester 0: a=0x0064, b=0xFFE2 -> req_ready[0] high the same cycle; next cycle rsp_valid=1, rsp_result=0x0046, rsp_overflow=0, rsp_id=0.
2. Saturation: a=0x7FFF, b=0x0001 -> rsp_result=0x7FFF, ovf=1; then a=0x8000, b=0xFFFF -> rsp_result=0x8000, ovf=1; ovf_count=2 after both handshakes.
3. All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later; one transaction per cycle.
4. Backpressure: rsp_ready low for 3 cycles while HOLD -> rsp_result/rsp_id/rsp_overflow unchanged, req_ready=0; rsp_ready high -> handshake and same-cycle grant of the next requester.
5. Counter: 300 overflowing handshakes with CNT_WIDTH=8 -> ovf_count=255; assert ovf_clear with a concurrent overflow handshake -> ovf_count=0.
6. Assert rst_n low asynchronously while HOLD with rsp_ready=0 -> rsp_valid drops to 0 without a clock edge; after release, the first grant goes to requester 0 (rr_ptr reset).

Source files
------------

// File: rtl/sat_add_arbiter.sv
// Shared signed saturating adder behind a round-robin arbiter.
// Up to NUM_REQ requesters compete for one adder. The winner's result,
// overflow flag and ID are registered and held until the single downstream
// port accepts them. A saturating counter tracks accepted overflow responses.

// Signed saturating adder: two's-complement sum clamped on overflow.
module sat_add_arbiter_sadd #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         ovf
);
  logic [W-1:0] sum;

  // Overflow only when both operands share a sign and the sum flips it.
  always_comb begin
    sum    = a + b;
    ovf    = (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1]);
    result = sum;
    if (ovf) result = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

module sat_add_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic [CNT_WIDTH-1:0]          ovf_count,
  input  logic                          ovf_clear
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] result;
    logic                  ovf;
  } rsp_t;

  state_e               state_q, state_d;
  rsp_t                 rsp_q, rsp_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] a_arr, b_arr;
  logic [DATA_WIDTH-1:0]              a_sel, b_sel, sum_sat;
  logic                               sum_ovf;
  logic                               rsp_hs, accept_en, grant_any, grant;
  logic [PTR_W-1:0]                   grant_idx;
  logic [PTR_W:0]                     scan_idx;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // A response leaves when held and accepted; a new one may enter the same cycle.
  assign rsp_hs    = (state_q == HOLD) & rsp_ready;
  assign accept_en = (state_q == IDLE) | rsp_hs;
  assign grant     = accept_en & grant_any;

  // Round-robin search from rr_ptr upward; scanning downward lets the
  // closest valid requester overwrite farther ones.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      if (req_valid[scan_idx[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Grant is combinational but forced off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (grant && rst_n) req_ready = NUM_REQ'(1) << grant_idx;
  end

  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];

  sat_add_arbiter_sadd #(.W(DATA_WIDTH)) u_sadd (
    .a      (a_sel),
    .b      (b_sel),
    .result (sum_sat),
    .ovf    (sum_ovf)
  );

  // Next-state: load response on grant, drop to IDLE when drained with no new grant.
  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      state_d      = HOLD;
      rsp_d.id     = ID_WIDTH'(grant_idx);
      rsp_d.result = sum_sat;
      rsp_d.ovf    = sum_ovf;
      rr_ptr_d     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end else if (rsp_hs) begin
      state_d = IDLE;
    end
  end

  // Overflow event counter: clear wins, otherwise saturating increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clear)                             ovf_cnt_d = '0;
    else if (rsp_hs && rsp_q.ovf && !(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
  end

  // All state, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rsp_q     <= '0;
      rr_ptr_q  <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      rr_ptr_q  <= rr_ptr_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign rsp_valid    = (state_q == HOLD);
  assign rsp_id       = rsp_q.id;
  assign rsp_result   = rsp_q.result;
  assign rsp_overflow = rsp_q.ovf;
  assign ovf_count    = ovf_cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Bench for sat_add_arbiter: directed scenarios plus random traffic.
// Grants are predicted by a round-robin model; expected responses are
// queued at grant time and popped by an independent response monitor.
module tb_sat_add_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_result;
  logic             rsp_overflow;
  logic [7:0]       ovf_count;
  logic             ovf_clear = 1'b0;

  sat_add_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(2), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        ovf;
  } exp_rsp_t;

  exp_rsp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr = 0;
  int m_out = 0;
  int m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, clamped to the signed 16-bit range.
  function automatic exp_rsp_t model(input int id, input logic [15:0] a, input logic [15:0] b);
    exp_rsp_t e;
    int s;
    s = int'($signed(a)) + int'($signed(b));
    e.id = id;
    e.ovf = 1'b1;
    if (s > 32767)       e.res = 16'h7FFF;
    else if (s < -32768) e.res = 16'h8000;
    else begin
      e.res = s[15:0];
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Grant predictor: who should be granted this cycle, and push its expected response.
  always @(negedge clk) begin : grant_mon
    int g;
    int i;
    logic [3:0] exp_rdy;
    if (!rst_n) begin
      m_ptr = 0;
      m_out = 0;
    end else begin
      chk("rsp_valid_vs_model", {31'b0, rsp_valid}, m_out);
      g = -1;
      if (!(m_out != 0 && !rsp_ready))
        for (int k = 0; k < NR; k++) begin
          i = (m_ptr + k) % NR;
          if (g < 0 && req_valid[i]) g = i;
        end
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
      if (m_out != 0 && rsp_ready) m_out = 0;
      if (g >= 0) begin
        exp_q.push_back(model(g, req_a[g*DW +: DW], req_b[g*DW +: DW]));
        m_ptr = (g + 1) % NR;
        m_out = 1;
      end
    end
  end

  // Response monitor: compare presented response to queue head, track overflow count.
  always @(negedge clk) begin : rsp_mon
    exp_rsp_t e;
    logic hs_ovf;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      chk("ovf_count", {24'b0, ovf_count}, m_cnt);
      hs_ovf = 1'b0;
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected_valid", {31'b0, rsp_valid}, 0);
        else begin
          e = exp_q[0];
          chk("rsp_id",       {30'b0, rsp_id}, e.id);
          chk("rsp_result",   {16'b0, rsp_result}, {16'b0, e.res});
          chk("rsp_overflow", {31'b0, rsp_overflow}, {31'b0, e.ovf});
          if (rsp_ready) begin
            hs_ovf = e.ovf;
            void'(exp_q.pop_front());
          end
        end
      end
      if (ovf_clear) m_cnt = 0;
      else if (hs_ovf && m_cnt < 255) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h7F00 + 16'($urandom_range(0, 255));
      3:       return 16'h8000 + 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin : stim
    logic [NR-1:0] acc;
    exp_rsp_t e2;

    // Reset state, including req_ready suppressed while requests are pending.
    #1 rst_n = 1'b0;
    req_valid = '1;
    #11;
    chk("rst_rsp_valid",  {31'b0, rsp_valid}, 0);
    chk("rst_rsp_result", {16'b0, rsp_result}, 0);
    chk("rst_rsp_id",     {30'b0, rsp_id}, 0);
    chk("rst_rsp_ovf",    {31'b0, rsp_overflow}, 0);
    chk("rst_ovf_count",  {24'b0, ovf_count}, 0);
    chk("rst_req_ready",  {28'b0, req_ready}, 0);
    req_valid = '0;
    cyc();
    rst_n = 1'b1;

    // Single requester, simple signed add.
    rsp_ready = 1'b1;
    set_op(0, 16'h0064, 16'hFFE2);
    req_valid = 4'b0001;
    cyc();
    chk("t1_valid",  {31'b0, rsp_valid}, 1);
    chk("t1_result", {16'b0, rsp_result}, 32'h0046);
    chk("t1_ovf",    {31'b0, rsp_overflow}, 0);
    chk("t1_id",     {30'b0, rsp_id}, 0);

    // Positive then negative saturation, back to back.
    set_op(0, 16'h7FFF, 16'h0001);
    cyc();
    chk("t2_pos_result", {16'b0, rsp_result}, 32'h7FFF);
    chk("t2_pos_ovf",    {31'b0, rsp_overflow}, 1);
    set_op(0, 16'h8000, 16'hFFFF);
    cyc();
    chk("t2_neg_result", {16'b0, rsp_result}, 32'h8000);
    chk("t2_neg_ovf",    {31'b0, rsp_overflow}, 1);
    req_valid = '0;
    cyc();
    chk("t2_count", {24'b0, ovf_count}, 2);
    chk("t2_idle",  {31'b0, rsp_valid}, 0);

    // Round-robin rotation from a freshly reset pointer.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_op(i, 16'(100 * (i + 1)), 16'(i + 7));
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_grant", {28'b0, req_ready}, 32'(1 << (k % NR)));
      cyc();
      chk("t3_rsp_id", {30'b0, rsp_id}, k % NR);
    end
    req_valid = '0;
    cyc();

    // Backpressure: response frozen, no grants, then same-cycle handover.
    rsp_ready = 1'b0;
    set_op(2, 16'h1234, 16'h4321);
    req_valid = 4'b0100;
    e2 = model(2, 16'h1234, 16'h4321);
    cyc();
    req_valid = 4'b1000;
    set_op(3, 16'h8000, 16'h8000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_ready_blocked", {28'b0, req_ready}, 0);
      cyc();
      chk("t4_hold_valid",  {31'b0, rsp_valid}, 1);
      chk("t4_hold_result", {16'b0, rsp_result}, {16'b0, e2.res});
      chk("t4_hold_id",     {30'b0, rsp_id}, 2);
      chk("t4_hold_ovf",    {31'b0, rsp_overflow}, {31'b0, e2.ovf});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_handover_grant", {28'b0, req_ready}, 32'b1000);
    cyc();
    chk("t4_next_id",     {30'b0, rsp_id}, 3);
    chk("t4_next_result", {16'b0, rsp_result}, 32'h8000);
    req_valid = '0;
    cyc();

    // Counter saturation, then clear racing an overflow handshake.
    set_op(0, 16'h7FFF, 16'h7FFF);
    req_valid = 4'b0001;
    repeat (300) cyc();
    chk("t5_count_sat", {24'b0, ovf_count}, 255);
    req_valid = '0;
    ovf_clear = 1'b1;
    cyc();
    chk("t5_clear_priority", {24'b0, ovf_count}, 0);
    ovf_clear = 1'b0;

    // Asynchronous reset while holding a stalled response.
    rsp_ready = 1'b0;
    set_op(1, 16'h0005, 16'h0006);
    req_valid = 4'b0010;
    cyc();
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, rsp_valid}, 0);
    chk("t6_async_ready", {28'b0, req_ready}, 0);
    chk("t6_async_count", {24'b0, ovf_count}, 0);
    cyc();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_first_grant", {28'b0, req_ready}, 32'b0001);
    cyc();
    chk("t6_first_id", {30'b0, rsp_id}, 0);
    req_valid = '0;
    cyc();

    // Random traffic; requesters hold valid and operands until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      cyc();
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          set_op(i, rnd_op(), rnd_op());
        end
      rsp_ready = ($urandom_range(0, 9) < 7);
      ovf_clear = ($urandom_range(0, 29) == 0);
    end

    // Drain and confirm nothing is left outstanding.
    @(negedge clk);
    cyc();
    req_valid = '0;
    rsp_ready = 1'b1;
    ovf_clear = 1'b0;
    repeat (3) cyc();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_rsp_valid",   {31'b0, rsp_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
